// File: rtl/alu_ctrl_mdu.sv
// ALU control decode (combinational) plus iterative unsigned MULTU/DIVU with HI/LO; result WIDTH+1 cycles after issue.
// stall_o holds the issuing instruction in decode from issue until the op finishes; divide-by-zero finishes the next cycle.
module alu_ctrl_mdu #(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 4,
  parameter int FUNCT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    ALUOp_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [WIDTH-1:0]   rs_data_i,
  input  logic [WIDTH-1:0]   rt_data_i,
  output logic [3:0]         ALUCtrl_o,
  output logic               Sign_extend_o,
  output logic               Mux_ALU_src1,
  output logic [1:0]         hilo_sel_o,
  output logic [WIDTH-1:0]   hilo_data_o,
  output logic               stall_o,
  output logic               done_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [OP_W-1:0] OP_R     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);

  localparam logic [FUNCT_W-1:0] F_ADDU  = FUNCT_W'(6'b100001);
  localparam logic [FUNCT_W-1:0] F_SUBU  = FUNCT_W'(6'b100011);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SRA   = FUNCT_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] F_SRAV  = FUNCT_W'(6'b000111);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADDU = 4'd4;
  localparam logic [3:0] ALU_SUBU = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SRAV = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_SLTU = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor
  logic [WIDTH-1:0] acc_q;    // running product upper half or partial remainder
  logic [WIDTH-1:0] sh_q;     // multiplier bits shifting out / dividend-quotient shift register
  logic [CW-1:0]    cnt_q;

  logic             is_r, is_mul, is_div, start, last, div_zero;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_diff;
  logic             div_bit;
  logic [WIDTH-1:0] div_rem;

  always_comb begin
    ALUCtrl_o     = ALU_AND;
    Sign_extend_o = 1'b0;
    hilo_sel_o    = 2'b00;
    case (ALUOp_i)
      OP_R: begin
        case (funct_i)
          F_ADDU:  ALUCtrl_o = ALU_ADDU;
          F_SUBU:  ALUCtrl_o = ALU_SUBU;
          F_AND:   ALUCtrl_o = ALU_AND;
          F_OR:    ALUCtrl_o = ALU_OR;
          F_SLT:   ALUCtrl_o = ALU_SLT;
          F_SRA:   ALUCtrl_o = ALU_SRA;
          F_SRAV:  ALUCtrl_o = ALU_SRAV;
          F_MFHI:  hilo_sel_o = 2'b01;
          F_MFLO:  hilo_sel_o = 2'b10;
          default: ;
        endcase
      end
      OP_ADDI:  begin ALUCtrl_o = ALU_ADDU; Sign_extend_o = 1'b1; end
      OP_SLTIU: ALUCtrl_o = ALU_SLTU;
      OP_BEQ:   begin ALUCtrl_o = ALU_SUBU; Sign_extend_o = 1'b1; end
      OP_BNE:   begin ALUCtrl_o = ALU_SUBU; Sign_extend_o = 1'b1; end
      OP_LUI:   ALUCtrl_o = ALU_LUI;
      OP_ORI:   ALUCtrl_o = ALU_OR;
      default:  ;
    endcase
  end

  assign Mux_ALU_src1 = (ALUOp_i == OP_R) && (funct_i == F_SRA);
  assign hilo_data_o  = (hilo_sel_o == 2'b01) ? hi_q :
                        (hilo_sel_o == 2'b10) ? lo_q : '0;

  assign is_r     = (ALUOp_i == OP_R);
  assign is_mul   = is_r && (funct_i == F_MULTU);
  assign is_div   = is_r && (funct_i == F_DIVU);
  assign start    = valid_i && !rst_i && (is_mul || is_div) && (state_q == IDLE);
  assign div_zero = (rt_data_i == '0);
  assign last     = (cnt_q == CW'(WIDTH - 1));

  assign stall_o = !rst_i && (start || state_q == MUL || state_q == DIV);
  assign done_o  = !rst_i && (state_q == DONE);

  // One shift-add step: add multiplicand when the current multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  // One restoring step: trial-subtract divisor from {remainder, next dividend bit}.
  assign div_diff = {1'b0, acc_q, sh_q[WIDTH-1]} - {2'b00, opnd_q};
  assign div_bit  = !div_diff[WIDTH+1];
  assign div_rem  = div_bit ? div_diff[WIDTH-1:0] : {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = is_mul ? MUL : (div_zero ? DONE : DIV);
      MUL:  if (last) state_d = DONE;
      DIV:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd_q <= rt_data_i;
            acc_q  <= '0;
            sh_q   <= rs_data_i;
            cnt_q  <= '0;
            if (is_div && div_zero) begin
              lo_q <= '1;
              hi_q <= rs_data_i;
            end
          end
        end
        MUL: begin
          acc_q <= mul_sum[WIDTH:1];
          sh_q  <= {mul_sum[0], sh_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            hi_q <= mul_sum[WIDTH:1];
            lo_q <= {mul_sum[0], sh_q[WIDTH-1:1]};
          end
        end
        DIV: begin
          acc_q <= div_rem;
          sh_q  <= {sh_q[WIDTH-2:0], div_bit};
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            hi_q <= div_rem;
            lo_q <= {sh_q[WIDTH-2:0], div_bit};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed bench for alu_ctrl_mdu: decode sweep, MULTU/DIVU timing and results via a result scoreboard, reset abort.
module tb_alu_ctrl_mdu;
  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [3:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] rs, rt;
  logic [3:0]   alu_ctrl;
  logic         sign_ext, src1_sel;
  logic [1:0]   hilo_sel;
  logic [W-1:0] hilo_data;
  logic         stall, done;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.WIDTH(W), .OP_W(4), .FUNCT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ALUOp_i(alu_op), .funct_i(funct),
    .rs_data_i(rs), .rt_data_i(rt), .ALUCtrl_o(alu_ctrl), .Sign_extend_o(sign_ext),
    .Mux_ALU_src1(src1_sel), .hilo_sel_o(hilo_sel), .hilo_data_o(hilo_data),
    .stall_o(stall), .done_o(done)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  typedef struct packed {
    logic [3:0] op;
    logic [5:0] f;
    logic [7:0] exp;   // {ALUCtrl, Sign_extend, Mux_ALU_src1, hilo_sel}
  } dec_t;

  res_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  dec_t tbl[18] = '{
    '{4'd1, 6'b000000, 8'h48}, '{4'd2, 6'b000000, 8'hB0}, '{4'd3, 6'b000000, 8'h58},
    '{4'd4, 6'b000000, 8'hA0}, '{4'd5, 6'b000011, 8'h10}, '{4'd6, 6'b000000, 8'h58},
    '{4'd0, 6'b000011, 8'h84}, '{4'd0, 6'b000111, 8'h90}, '{4'd0, 6'b101010, 8'h60},
    '{4'd0, 6'b100001, 8'h40}, '{4'd0, 6'b100011, 8'h50}, '{4'd0, 6'b100100, 8'h00},
    '{4'd0, 6'b100101, 8'h10}, '{4'd0, 6'b111111, 8'h00}, '{4'd0, 6'b010000, 8'h01},
    '{4'd0, 6'b010010, 8'h02}, '{4'd0, 6'b011001, 8'h00}, '{4'd9, 6'b000011, 8'h00}
  };

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational HI/LO read through the MFHI/MFLO decode path (no clock edge needed).
  task automatic read_hilo(input string tag, output logic [W-1:0] h, output logic [W-1:0] l);
    alu_op = 4'd0;
    funct  = F_MFHI;
    #1;
    check({tag, " mfhi_sel"}, 64'(hilo_sel), 64'(2'b01));
    h = hilo_data;
    funct = F_MFLO;
    #1;
    l = hilo_data;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_done, input bit hold);
    res_t         e;
    res_t         r;
    int           stalls;
    int           cyc;
    bit           got;
    logic [W-1:0] h, l;
    if (f == F_MULTU)  e = {32'b0, a} * {32'b0, b};
    else if (b == '0)  e = {a, 32'hFFFF_FFFF};
    else               e = {a % b, a / b};
    sb.push_back(e);
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 4'd0; funct = f; rs = a; rt = b;
    stalls = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (stall) stalls++;
        cyc++;
        @(posedge clk); #1;
        if (!hold) valid = 1'b0;
      end
    end
    check({tag, " done_cycle"}, 64'(cyc), 64'(exp_done));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(exp_done));
    check({tag, " stall_in_done"}, 64'(stall), 64'd0);
    r = (sb.size() > 0) ? sb.pop_front() : '0;
    read_hilo(tag, h, l);
    check({tag, " hi"}, 64'(h), 64'(r.hi));
    check({tag, " lo"}, 64'(l), 64'(r.lo));
    valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " idle_after"}, 64'({stall, done}), 64'd0);
  endtask

  initial begin
    logic [W-1:0] h, l;
    int           dn;
    rst = 1'b1; valid = 1'b0; alu_op = 4'd0; funct = 6'd0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset stall/done", 64'({stall, done}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    read_hilo("reset", h, l);
    check("reset hi", 64'(h), 64'd0);
    check("reset lo", 64'(l), 64'd0);

    foreach (tbl[i]) begin
      alu_op = tbl[i].op;
      funct  = tbl[i].f;
      #1;
      check($sformatf("decode[%0d]", i), 64'({alu_ctrl, sign_ext, src1_sel, hilo_sel}), 64'(tbl[i].exp));
      check($sformatf("decode_stall[%0d]", i), 64'(stall), 64'd0);
    end

    run_op("multu 7*6", F_MULTU, 32'd7, 32'd6, W + 1, 1'b0);
    run_op("multu max*max held", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1, 1'b1);
    run_op("divu 100/7", F_DIVU, 32'd100, 32'd7, W + 1, 1'b0);
    run_op("divu 5/0", F_DIVU, 32'd5, 32'd0, 1, 1'b0);
    run_op("divu big", F_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, W + 1, 1'b1);

    // Reset five cycles into a MULTU: abort with no done pulse and cleared HI/LO.
    @(posedge clk); #1;
    valid = 1'b1; alu_op = 4'd0; funct = F_MULTU; rs = 32'd9; rt = 32'd9;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort stall", 64'(stall), 64'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort done pulses", 64'(dn), 64'd0);
    read_hilo("abort", h, l);
    check("abort hi", 64'(h), 64'd0);
    check("abort lo", 64'(l), 64'd0);
    run_op("multu after reset", F_MULTU, 32'd3, 32'd5, W + 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
